// File: rtl/sram_bus_arbiter.sv
// Arbitrates one single-port synchronous SRAM between instruction fetch and
// data access; one command per transaction, registered data with a done pulse.
module sram_bus_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DATA_PRIO = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ins_req,
  input  logic [ADDR_W-1:0]   ins_addr,
  output logic [DATA_W-1:0]   ins_rdata,
  output logic                ins_done,
  output logic                ins_stall,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_be,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_done,
  output logic                data_stall,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_wen,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata,
  output logic [31:0]         conflict_cnt
);

  typedef enum logic [1:0] {IDLE, RESP_I, RESP_D} state_t;

  state_t state, state_nxt;
  logic   last_data, last_data_nxt;
  logic   resp_wr, resp_wr_nxt;
  logic   ins_el, data_el, tie, grant_i, grant_d;

  // A requester whose done is high is still holding req for the finished
  // transaction, so it must not be granted again in that cycle.
  assign ins_el     = ins_req && !ins_done;
  assign data_el    = data_req && !data_done;
  assign ins_stall  = ins_el;
  assign data_stall = data_el;

  always_comb begin
    state_nxt     = state;
    last_data_nxt = last_data;
    resp_wr_nxt   = resp_wr;
    tie           = 1'b0;
    grant_i       = 1'b0;
    grant_d       = 1'b0;
    sram_en       = 1'b0;
    sram_wen      = '0;
    sram_addr     = '0;
    sram_wdata    = data_wdata;
    unique case (state)
      IDLE: begin
        tie = ins_el && data_el;
        if (data_el && (!ins_el || DATA_PRIO != 0 || !last_data))
          grant_d = 1'b1;
        else if (ins_el)
          grant_i = 1'b1;
        if (grant_d) begin
          sram_en       = 1'b1;
          sram_addr     = data_addr;
          if (data_wr)
            sram_wen    = data_be;
          state_nxt     = RESP_D;
          last_data_nxt = 1'b1;
          resp_wr_nxt   = data_wr;
        end else if (grant_i) begin
          sram_en       = 1'b1;
          sram_addr     = ins_addr;
          state_nxt     = RESP_I;
          last_data_nxt = 1'b0;
        end
      end
      RESP_I, RESP_D: state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_data    <= 1'b1;
      resp_wr      <= 1'b0;
      ins_done     <= 1'b0;
      data_done    <= 1'b0;
      ins_rdata    <= '0;
      data_rdata   <= '0;
      conflict_cnt <= '0;
    end else begin
      state     <= state_nxt;
      last_data <= last_data_nxt;
      resp_wr   <= resp_wr_nxt;
      ins_done  <= (state == RESP_I);
      data_done <= (state == RESP_D);
      if (state == RESP_I)
        ins_rdata <= sram_rdata;
      if (state == RESP_D && !resp_wr)
        data_rdata <= sram_rdata;
      if (tie && conflict_cnt != '1)
        conflict_cnt <= conflict_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: two instances (DATA_PRIO=1 and 0), each with its
// own SRAM and requesters, checked every cycle against a transaction scheduler.
module tb_sram_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          ins_req    [2];
  logic [AW-1:0] ins_addr   [2];
  logic [DW-1:0] ins_rdata  [2];
  logic          ins_done   [2];
  logic          ins_stall  [2];
  logic          data_req   [2];
  logic          data_wr    [2];
  logic [BW-1:0] data_be    [2];
  logic [AW-1:0] data_addr  [2];
  logic [DW-1:0] data_wdata [2];
  logic [DW-1:0] data_rdata [2];
  logic          data_done  [2];
  logic          data_stall [2];
  logic          sram_en    [2];
  logic [BW-1:0] sram_wen   [2];
  logic [AW-1:0] sram_addr  [2];
  logic [DW-1:0] sram_wdata [2];
  logic [DW-1:0] sram_rdata [2];
  logic [31:0]   conflict_cnt [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DATA_PRIO(g == 0 ? 1 : 0)) u_dut (
      .clk(clk), .rst(rst),
      .ins_req(ins_req[g]), .ins_addr(ins_addr[g]), .ins_rdata(ins_rdata[g]),
      .ins_done(ins_done[g]), .ins_stall(ins_stall[g]),
      .data_req(data_req[g]), .data_wr(data_wr[g]), .data_be(data_be[g]),
      .data_addr(data_addr[g]), .data_wdata(data_wdata[g]), .data_rdata(data_rdata[g]),
      .data_done(data_done[g]), .data_stall(data_stall[g]),
      .sram_en(sram_en[g]), .sram_wen(sram_wen[g]), .sram_addr(sram_addr[g]),
      .sram_wdata(sram_wdata[g]), .sram_rdata(sram_rdata[g]),
      .conflict_cnt(conflict_cnt[g])
    );
  end

  function automatic logic [DW-1:0] init_word(input int unsigned i);
    case (i)
      4:       return 32'hDEAD_BEEF;
      8:       return 32'hAAAA_AAAA;
      default: return 32'h5A5A_5A5A ^ (i * 32'h0103_0507);
    endcase
  endfunction

  function automatic int unsigned widx(input logic [AW-1:0] a);
    return 32'(a[13:10]);
  endfunction

  // SRAM environment: byte-write, one-cycle read latency, reloaded on reset.
  logic [DW-1:0] smem [2][16];
  always @(posedge clk)
    for (int k = 0; k < 2; k++)
      if (rst) begin
        for (int i = 0; i < 16; i++) smem[k][i] <= init_word(i);
      end else if (sram_en[k]) begin
        for (int b = 0; b < BW; b++)
          if (sram_wen[k][b])
            smem[k][widx(sram_addr[k])][8*b +: 8] <= sram_wdata[k][8*b +: 8];
        sram_rdata[k] <= smem[k][widx(sram_addr[k])];
      end

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Reference: a transaction scheduler. The bus is free from free_at onward;
  // a granted request completes exactly two cycles after its grant.
  int            free_at  [2];
  int            idone_at [2];
  int            ddone_at [2];
  bit            last_d   [2];
  logic [31:0]   cnt      [2];
  logic [DW-1:0] exp_ird  [2];
  logic [DW-1:0] exp_drd  [2];
  logic [DW-1:0] pend_ird [2];
  logic [DW-1:0] pend_drd [2];
  bit            pend_dwr [2];
  logic [DW-1:0] rmem     [2][16];
  bit            ins_pend [2];
  bit            data_pend[2];
  bit            rnd_mode, hold_mode, want_rst;

  task automatic model_reset(input int k);
    free_at[k]  = 0;
    idone_at[k] = -10;
    ddone_at[k] = -10;
    last_d[k]   = 1'b1;
    cnt[k]      = '0;
    exp_ird[k]  = '0;
    exp_drd[k]  = '0;
    pend_dwr[k] = 1'b0;
    ins_pend[k] = 1'b0;
    data_pend[k] = 1'b0;
    for (int i = 0; i < 16; i++) rmem[k][i] = init_word(i);
  endtask

  task automatic model_eval(input int k);
    bit idone, ddone, iel, del, can, gd, gi;
    logic [BW-1:0] ewen;
    int unsigned w;
    idone = (idone_at[k] == cyc);
    ddone = (ddone_at[k] == cyc);
    if (idone) exp_ird[k] = pend_ird[k];
    if (ddone && !pend_dwr[k]) exp_drd[k] = pend_drd[k];
    iel = ins_req[k] && !idone;
    del = data_req[k] && !ddone;
    can = (cyc >= free_at[k]);
    gd  = can && del && (!iel || k == 0 || !last_d[k]);
    gi  = can && iel && !gd;
    ewen = (gd && data_wr[k]) ? data_be[k] : '0;

    check($sformatf("ins_done[%0d]", k),   64'(ins_done[k]),   64'(idone));
    check($sformatf("data_done[%0d]", k),  64'(data_done[k]),  64'(ddone));
    check($sformatf("ins_rdata[%0d]", k),  64'(ins_rdata[k]),  64'(exp_ird[k]));
    check($sformatf("data_rdata[%0d]", k), 64'(data_rdata[k]), 64'(exp_drd[k]));
    check($sformatf("ins_stall[%0d]", k),  64'(ins_stall[k]),  64'(iel));
    check($sformatf("data_stall[%0d]", k), 64'(data_stall[k]), 64'(del));
    check($sformatf("conflict_cnt[%0d]", k), 64'(conflict_cnt[k]), 64'(cnt[k]));
    check($sformatf("sram_en[%0d]", k),    64'(sram_en[k]),    64'(gd || gi));
    check($sformatf("sram_wen[%0d]", k),   64'(sram_wen[k]),   64'(ewen));
    if (gd || gi)
      check($sformatf("sram_addr[%0d]", k), 64'(sram_addr[k]), 64'(gd ? data_addr[k] : ins_addr[k]));
    if (gd && data_wr[k])
      check($sformatf("sram_wdata[%0d]", k), 64'(sram_wdata[k]), 64'(data_wdata[k]));

    if (can && iel && del && cnt[k] != 32'hFFFF_FFFF) cnt[k] = cnt[k] + 32'd1;
    if (gd) begin
      last_d[k]   = 1'b1;
      free_at[k]  = cyc + 2;
      ddone_at[k] = cyc + 2;
      pend_dwr[k] = data_wr[k];
      w = widx(data_addr[k]);
      pend_drd[k] = rmem[k][w];
      if (data_wr[k])
        for (int b = 0; b < BW; b++)
          if (data_be[k][b]) rmem[k][w][8*b +: 8] = data_wdata[k][8*b +: 8];
    end
    if (gi) begin
      last_d[k]   = 1'b0;
      free_at[k]  = cyc + 2;
      idone_at[k] = cyc + 2;
      pend_ird[k] = rmem[k][widx(ins_addr[k])];
    end
  endtask

  // Requester agents: hold req through done, optionally re-request, drop
  // before grant, or wiggle the sampled fields while a transaction is in flight.
  task automatic agent(input int k);
    if (want_rst) begin
      ins_pend[k]  = 1'b0;
      data_pend[k] = 1'b0;
    end else begin
      if (ins_pend[k] && idone_at[k] == cyc - 1) ins_pend[k] = 1'b0;
      if (data_pend[k] && ddone_at[k] == cyc - 1) data_pend[k] = 1'b0;
      if (hold_mode) begin
        ins_pend[k]  = 1'b1;
        data_pend[k] = 1'b1;
      end
      if (rnd_mode) begin
        if (!ins_pend[k]) begin
          if ($urandom_range(0, 2) == 0) begin
            ins_pend[k] = 1'b1;
            ins_addr[k] = $urandom;
          end
        end else if (idone_at[k] > cyc) begin
          ins_addr[k] = $urandom;
        end else if (idone_at[k] < cyc && $urandom_range(0, 15) == 0) begin
          ins_pend[k] = 1'b0;
        end
        if (!data_pend[k] && $urandom_range(0, 2) == 0) begin
          data_pend[k] = 1'b1;
        end else if (data_pend[k] && ddone_at[k] < cyc && $urandom_range(0, 15) == 0) begin
          data_pend[k] = 1'b0;
        end
        if ((data_pend[k] && ddone_at[k] < cyc && ddone_at[k] != cyc - 1) || ddone_at[k] > cyc
            || (data_pend[k] && ddone_at[k] == cyc - 1)) begin
          data_wr[k]    = 1'($urandom_range(0, 1));
          data_be[k]    = 4'($urandom_range(0, 15));
          data_addr[k]  = $urandom;
          data_wdata[k] = $urandom;
        end
      end
    end
    ins_req[k]  = ins_pend[k] && !(rnd_mode && idone_at[k] > cyc && $urandom_range(0, 3) == 0);
    data_req[k] = data_pend[k] && !(rnd_mode && ddone_at[k] > cyc && $urandom_range(0, 3) == 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    rst = want_rst;
    for (int k = 0; k < 2; k++) agent(k);
    #3;
    for (int k = 0; k < 2; k++)
      if (want_rst) model_reset(k);
      else model_eval(k);
  endtask

  task automatic issue_ins(input logic [AW-1:0] a);
    for (int k = 0; k < 2; k++) begin
      ins_pend[k] = 1'b1;
      ins_addr[k] = a;
    end
  endtask

  task automatic issue_data(input logic wr, input logic [BW-1:0] be,
                            input logic [AW-1:0] a, input logic [DW-1:0] wd);
    for (int k = 0; k < 2; k++) begin
      data_pend[k]  = 1'b1;
      data_wr[k]    = wr;
      data_be[k]    = be;
      data_addr[k]  = a;
      data_wdata[k] = wd;
    end
  endtask

  initial begin
    rst = 1'b1;
    rnd_mode = 1'b0;
    hold_mode = 1'b0;
    want_rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ins_req[k] = 1'b0;  ins_addr[k] = '0;
      data_req[k] = 1'b0; data_wr[k] = 1'b0; data_be[k] = '0;
      data_addr[k] = '0;  data_wdata[k] = '0;
      model_reset(k);
    end

    repeat (2) tick();
    want_rst = 1'b0;
    repeat (10) tick();
    check("idle_conflict_cnt", 64'(conflict_cnt[0]), 64'd0);

    // Single fetch
    issue_ins(32'h0000_1000);
    tick();
    check("fetch_sram_en_T", 64'(sram_en[0]), 64'd1);
    check("fetch_stall_T", 64'(ins_stall[0]), 64'd1);
    tick();
    check("fetch_stall_T1", 64'(ins_stall[0]), 64'd1);
    tick();
    check("fetch_done_T2", 64'(ins_done[0]), 64'd1);
    check("fetch_rdata_T2", 64'(ins_rdata[0]), 64'hDEAD_BEEF);
    check("fetch_stall_T2", 64'(ins_stall[0]), 64'd0);
    tick();

    // Partial write then read back
    issue_data(1'b1, 4'b0011, 32'h0000_2000, 32'h1234_5678);
    tick();
    check("wr_sram_wen_T", 64'(sram_wen[0]), 64'h3);
    tick();
    tick();
    check("wr_done_T2", 64'(data_done[0]), 64'd1);
    tick();
    issue_data(1'b0, 4'b1111, 32'h0000_2000, 32'h0);
    repeat (3) tick();
    check("rd_rdata", 64'(data_rdata[0]), 64'hAAAA_5678);
    tick();

    // Tie
    issue_ins(32'h0000_1000);
    issue_data(1'b0, 4'b0000, 32'h0000_2000, 32'h0);
    repeat (3) tick();
    check("tie_data_done_T2", 64'(data_done[0]), 64'd1);
    repeat (2) tick();
    check("tie_ins_done_T4", 64'(ins_done[0]), 64'd1);
    tick();
    check("tie_conflict_p1", 64'(conflict_cnt[0]), 64'd1);
    check("tie_conflict_p0", 64'(conflict_cnt[1]), 64'd1);

    // Both held continuously
    issue_ins(32'h0000_1000);
    issue_data(1'b0, 4'b0000, 32'h0000_2000, 32'h0);
    hold_mode = 1'b1;
    repeat (12) tick();
    hold_mode = 1'b0;
    repeat (8) tick();

    // Reset in the middle of a transaction
    issue_ins(32'h0000_1000);
    tick();
    want_rst = 1'b1;
    tick();
    want_rst = 1'b0;
    tick();
    check("midrst_no_done", 64'(ins_done[0]), 64'd0);
    check("midrst_rdata", 64'(ins_rdata[0]), 64'd0);
    issue_ins(32'h0000_1000);
    repeat (3) tick();
    check("postrst_done", 64'(ins_done[0]), 64'd1);
    check("postrst_rdata", 64'(ins_rdata[0]), 64'hDEAD_BEEF);
    tick();

    // Randomized traffic with occasional resets
    rnd_mode = 1'b1;
    repeat (3000) begin
      want_rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    want_rst = 1'b0;
    rnd_mode = 1'b0;
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one synchronous single-port SRAM between the instruction-fetch requester and the data-access requester.
- Sits directly upstream of the SRAM stall adapters. It accepts held requests, issues one SRAM command per transaction, and returns registered read data with a one-cycle `done` pulse.
- Stall outputs feed the pipeline stall logic in place of raw adapter stalls.
- Latency: 2 cycles from grant to `done`. Data side has priority by default.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- DATA_PRIO, 1, arbitration mode. 1 = data always wins a tie. 0 = alternate on tie, using the last grant.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- ins_req  in  1  fetch request; held until ins_done.
- ins_addr  in  ADDR_W  fetch address.
- ins_rdata  out  DATA_W  fetched word; valid while ins_done=1, held afterwards.
- ins_done  out  1  one-cycle completion pulse.
- ins_stall  out  1  ins_req && !ins_done.
- data_req  in  1  data request; held until data_done.
- data_wr  in  1  1 = write, 0 = read.
- data_be  in  DATA_W/8  byte enables for writes.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  DATA_W  write data.
- data_rdata  out  DATA_W  read word; valid while data_done=1, held afterwards.
- data_done  out  1  one-cycle completion pulse (reads and writes).
- data_stall  out  1  data_req && !data_done.
- sram_en  out  1  SRAM access enable.
- sram_wen  out  DATA_W/8  SRAM byte write enables; 0 for reads.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data, valid 1 cycle after sram_en.
- conflict_cnt  out  32  count of cycles where both requests were eligible in IDLE; saturates at 0xFFFFFFFF.

Behaviour:
- Reset values (rst=1 at posedge):
  - state=IDLE.
  - ins_done=0, data_done=0, ins_rdata=0, data_rdata=0, conflict_cnt=0, last_grant=data.
  - Reset mid-transaction abandons that transaction; no done is issued for it.
- State machine has three states: IDLE, RESP_I, RESP_D.
- IDLE:
  - Eligibility: ins eligible = ins_req && !ins_done; data eligible = data_req && !data_done. A requester whose done is high this cycle is never re-granted, which prevents a double issue on a still-held req.
  - Data only eligible: grant data, next state RESP_D.
  - Ins only eligible: grant ins, next state RESP_I.
  - Both eligible, DATA_PRIO=1: grant data.
  - Both eligible, DATA_PRIO=0: grant opposite of last_grant.
  - Any tie increments conflict_cnt.
  - Grant updates last_grant.
  - SRAM command is driven combinationally in the grant cycle:
    - sram_en=1.
    - sram_addr = granted addr.
    - sram_wen = data_be when data_wr, else 0.
    - sram_wdata = data_wdata.
    - Ins grants always read, with sram_wen=0.
  - No grant: sram_en=0, sram_wen=0.
- RESP_I / RESP_D:
  - sram_en=0.
  - Capture sram_rdata into ins_rdata or data_rdata; data_rdata is captured only for reads, writes leave it unchanged.
  - Set the matching done register to 1 for the next cycle.
  - Next state IDLE.
- done lasts exactly one cycle and coincides with a cycle in IDLE. In that IDLE cycle the other requester may be granted, giving back-to-back service.
- Throughput: one transaction per 2 cycles. Each requester sees grant→done = 2 cycles.
- Requester signals (addr/wr/be/wdata) are sampled only in the grant cycle. Changes while in RESP_x are ignored.
- A req dropped before grant is never serviced. A req dropped after grant still completes, and done pulses.
- sram_wen for ins, or for a data read, is always all-zero.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then all reqs 0 → all outputs 0; sram_en=0 for 10 cycles; conflict_cnt=0.
- Single fetch: ins_req=1, ins_addr=0x1000; SRAM model returns 0xDEADBEEF → sram_en=1 at T, ins_done=1 and ins_rdata=0xDEADBEEF at T+2, ins_stall=1 at T and T+1, 0 at T+2.
- Data write then read: write addr 0x2000, be=4'b0011, wdata=0x12345678 → sram_wen=4'b0011 at T, data_done at T+2. Then read 0x2000 on a 0xAAAA_AAAA-preloaded model → data_rdata=0xAAAA5678.
- Tie, DATA_PRIO=1: both reqs at T → data granted at T, ins granted at T+2, data_done at T+2, ins_done at T+4, conflict_cnt=1.
- Tie, DATA_PRIO=0, both held continuously for 8 cycles → grants alternate data, ins, data, ins; each done spaced 2 cycles.
- Reset mid-op: grant at T, rst=1 at T+1 → no done at T+2; state IDLE; outputs 0; a fresh request after reset completes normally.
